vga_timing_pipe: RTL and testbench

- Parametrised single-clock successor to the team's 640x480 VGA controller, for the DE10 VGA output path.
- Generates horizontal and vertical timing, pixel requests, X/Y coordinates and a linear frame-buffer address.
- Issues each pixel request REQ_LEAD cycles ahead of display, so a pipelined memory or Sobel stage can return data in time. Sync and blank are delayed to match.
- Both counters run on iCLK; there is no clocking from the HS edge.

---
 rtl/vga_timing_pipe_if.sv | 36 +++
 rtl/vga_timing_pipe.sv | 219 +++++++++++++++++++++
 tb/tb_vga_timing_pipe.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_pipe_if.sv
// Signal bundle between vga_timing_pipe and its pixel source / VGA DAC.
// The master side drives the request bus and the DAC outputs, and the slave side returns pixel colour.
interface vga_timing_pipe_if #(
    parameter int COLOR_W = 10,
    parameter int ADDR_W  = 22
);
    logic               oRequest;
    logic [10:0]        oCurrent_X;
    logic [10:0]        oCurrent_Y;
    logic [ADDR_W-1:0]  oAddress;
    logic               oFrame_Start;
    logic               oLine_Start;
    logic [COLOR_W-1:0] iRed;
    logic [COLOR_W-1:0] iGreen;
    logic [COLOR_W-1:0] iBlue;
    logic [COLOR_W-1:0] oVGA_R;
    logic [COLOR_W-1:0] oVGA_G;
    logic [COLOR_W-1:0] oVGA_B;
    logic               oVGA_HS;
    logic               oVGA_VS;
    logic               oVGA_BLANK;
    logic               oVGA_SYNC;
    logic               oVGA_CLOCK;

    modport master (
        output oRequest, oCurrent_X, oCurrent_Y, oAddress, oFrame_Start, oLine_Start,
        output oVGA_R, oVGA_G, oVGA_B, oVGA_HS, oVGA_VS, oVGA_BLANK, oVGA_SYNC, oVGA_CLOCK,
        input  iRed, iGreen, iBlue
    );

    modport slave (
        input  oRequest, oCurrent_X, oCurrent_Y, oAddress, oFrame_Start, oLine_Start,
        input  oVGA_R, oVGA_G, oVGA_B, oVGA_HS, oVGA_VS, oVGA_BLANK, oVGA_SYNC, oVGA_CLOCK,
        output iRed, iGreen, iBlue
    );
endinterface

// File: rtl/vga_timing_pipe.sv
// Parametrised VGA timing generator that issues pixel requests REQ_LEAD cycles ahead of display.
// Sync and blank are delayed by the same amount so that they line up with the returned pixel data.
module vga_timing_pipe #(
    parameter int H_FRONT  = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int H_ACT    = 640,
    parameter int V_FRONT  = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter int V_ACT    = 480,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int REQ_LEAD = 2,
    parameter int COLOR_W  = 10,
    parameter int ADDR_W   = 22
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    vga_timing_pipe_if.master bus
);
    localparam int H_BLANK = H_FRONT + H_SYNC + H_BACK;
    localparam int H_TOTAL = H_BLANK + H_ACT;
    localparam int V_BLANK = V_FRONT + V_SYNC + V_BACK;
    localparam int V_TOTAL = V_BLANK + V_ACT;
    localparam int HCW     = $clog2(H_TOTAL);
    localparam int VCW     = $clog2(V_TOTAL);

    localparam logic [HCW-1:0]    H_LAST    = HCW'(H_TOTAL - 1);
    localparam logic [HCW-1:0]    H_ONE     = HCW'(1);
    localparam logic [HCW-1:0]    H_START   = HCW'(H_BLANK);
    localparam logic [VCW-1:0]    V_LAST    = VCW'(V_TOTAL - 1);
    localparam logic [VCW-1:0]    V_ONE     = VCW'(1);
    localparam logic [VCW-1:0]    V_START   = VCW'(V_BLANK);
    localparam logic [15:0]       H_SYNC_LO = 16'(H_FRONT);
    localparam logic [15:0]       H_SYNC_HI = 16'(H_FRONT + H_SYNC);
    localparam logic [15:0]       V_SYNC_LO = 16'(V_FRONT);
    localparam logic [15:0]       V_SYNC_HI = 16'(V_FRONT + V_SYNC);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic              HS_ACT    = (HS_POL != 0);
    localparam logic              VS_ACT    = (VS_POL != 0);

    // Half-open window test [lo, hi) on a zero-extended counter value.
    function automatic logic in_window(input logic [15:0] pos,
                                       input logic [15:0] lo,
                                       input logic [15:0] hi);
        return (pos >= lo) && (pos < hi);
    endfunction

    // h_q/v_q hold the position that stage 0 presents in the following cycle.
    logic [HCW-1:0]      h_q, h_d;
    logic [VCW-1:0]      v_q, v_d;
    logic [ADDR_W-1:0]   addr_cnt_q, addr_cnt_d;
    logic [ADDR_W-1:0]   addr_base;

    logic                req_q, req_d;
    logic [10:0]         x_q, x_d;
    logic [10:0]         y_q, y_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                frame_q, frame_d;
    logic                line_q, line_d;
    logic                hs0_q, hs0_d;
    logic                vs0_q, vs0_d;

    // Sync and data-enable flags are held active-high internally; polarity is applied at the output.
    logic [REQ_LEAD-1:0] hs_dly_q, hs_dly_d;
    logic [REQ_LEAD-1:0] vs_dly_q, vs_dly_d;
    logic [REQ_LEAD-1:0] de_dly_q, de_dly_d;

    logic [COLOR_W-1:0]  r_q, r_d;
    logic [COLOR_W-1:0]  g_q, g_d;
    logic [COLOR_W-1:0]  b_q, b_d;
    logic                blank_q, blank_d;
    logic                hs_q, hs_d;
    logic                vs_q, vs_d;

    // Raster counters: h wraps every line, v advances on the last h of each line.
    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            if (v_q == V_LAST) begin
                v_d = '0;
            end else begin
                v_d = v_q + V_ONE;
            end
        end else begin
            h_d = h_q + H_ONE;
        end
    end

    // Stage 0: request, coordinates, address and raw sync flags for position (h_q, v_q).
    always_comb begin
        req_d     = (h_q >= H_START) && (v_q >= V_START);
        frame_d   = (h_q == '0) && (v_q == '0);
        line_d    = (h_q == '0);
        hs0_d     = in_window(16'(h_q), H_SYNC_LO, H_SYNC_HI);
        vs0_d     = in_window(16'(v_q), V_SYNC_LO, V_SYNC_HI);
        addr_base = addr_cnt_q;
        if (frame_d) begin
            addr_base = '0;
        end else begin
            addr_base = addr_cnt_q;
        end
        if (req_d) begin
            x_d        = 11'(h_q - H_START);
            y_d        = 11'(v_q - V_START);
            addr_d     = addr_base;
            addr_cnt_d = addr_base + ADDR_ONE;
        end else begin
            x_d        = 11'b0;
            y_d        = 11'b0;
            addr_d     = '0;
            addr_cnt_d = addr_base;
        end
    end

    // Delay line: entry REQ_LEAD-1 carries the stage-0 flags from REQ_LEAD cycles earlier.
    always_comb begin
        hs_dly_d    = hs_dly_q;
        vs_dly_d    = vs_dly_q;
        de_dly_d    = de_dly_q;
        hs_dly_d[0] = hs0_q;
        vs_dly_d[0] = vs0_q;
        de_dly_d[0] = req_q;
        for (int i = 1; i < REQ_LEAD; i++) begin
            hs_dly_d[i] = hs_dly_q[i-1];
            vs_dly_d[i] = vs_dly_q[i-1];
            de_dly_d[i] = de_dly_q[i-1];
        end
    end

    // Output stage: host colour is captured together with the matching delayed flags.
    always_comb begin
        blank_d = de_dly_q[REQ_LEAD-1];
        if (de_dly_q[REQ_LEAD-1]) begin
            r_d = bus.iRed;
            g_d = bus.iGreen;
            b_d = bus.iBlue;
        end else begin
            r_d = '0;
            g_d = '0;
            b_d = '0;
        end
        if (hs_dly_q[REQ_LEAD-1]) begin
            hs_d = HS_ACT;
        end else begin
            hs_d = ~HS_ACT;
        end
        if (vs_dly_q[REQ_LEAD-1]) begin
            vs_d = VS_ACT;
        end else begin
            vs_d = ~VS_ACT;
        end
    end

    // All state, with synchronous active-low reset; reset also flushes requests in flight.
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            h_q        <= '0;
            v_q        <= '0;
            addr_cnt_q <= '0;
            req_q      <= 1'b0;
            x_q        <= 11'b0;
            y_q        <= 11'b0;
            addr_q     <= '0;
            frame_q    <= 1'b0;
            line_q     <= 1'b0;
            hs0_q      <= 1'b0;
            vs0_q      <= 1'b0;
            hs_dly_q   <= '0;
            vs_dly_q   <= '0;
            de_dly_q   <= '0;
            r_q        <= '0;
            g_q        <= '0;
            b_q        <= '0;
            blank_q    <= 1'b0;
            hs_q       <= ~HS_ACT;
            vs_q       <= ~VS_ACT;
        end else begin
            h_q        <= h_d;
            v_q        <= v_d;
            addr_cnt_q <= addr_cnt_d;
            req_q      <= req_d;
            x_q        <= x_d;
            y_q        <= y_d;
            addr_q     <= addr_d;
            frame_q    <= frame_d;
            line_q     <= line_d;
            hs0_q      <= hs0_d;
            vs0_q      <= vs0_d;
            hs_dly_q   <= hs_dly_d;
            vs_dly_q   <= vs_dly_d;
            de_dly_q   <= de_dly_d;
            r_q        <= r_d;
            g_q        <= g_d;
            b_q        <= b_d;
            blank_q    <= blank_d;
            hs_q       <= hs_d;
            vs_q       <= vs_d;
        end
    end

    assign bus.oRequest     = req_q;
    assign bus.oCurrent_X   = x_q;
    assign bus.oCurrent_Y   = y_q;
    assign bus.oAddress     = addr_q;
    assign bus.oFrame_Start = frame_q;
    assign bus.oLine_Start  = line_q;
    assign bus.oVGA_R       = r_q;
    assign bus.oVGA_G       = g_q;
    assign bus.oVGA_B       = b_q;
    assign bus.oVGA_BLANK   = blank_q;
    assign bus.oVGA_HS      = hs_q;
    assign bus.oVGA_VS      = vs_q;
    assign bus.oVGA_SYNC    = 1'b1;
    assign bus.oVGA_CLOCK   = iCLK;
endmodule

// File: tb/tb_vga_timing_pipe.sv
// Directed bench: a small raster (H 2/3/2/4, V 1/1/1/3) in both polarities plus the default 640x480 raster.
module tb_vga_timing_pipe;
    logic clk;
    logic rst_n;
    logic rst_big_n;
    int   checks_total;
    int   checks_passed;

    vga_timing_pipe_if #(.COLOR_W(10), .ADDR_W(22)) bs ();
    vga_timing_pipe_if #(.COLOR_W(10), .ADDR_W(22)) bi ();
    vga_timing_pipe_if #(.COLOR_W(10), .ADDR_W(22)) bb ();

    vga_timing_pipe #(
        .H_FRONT(2), .H_SYNC(3), .H_BACK(2), .H_ACT(4),
        .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .V_ACT(3),
        .HS_POL(0), .VS_POL(0), .REQ_LEAD(2), .COLOR_W(10), .ADDR_W(22)
    ) u_small (.iCLK(clk), .iRST_N(rst_n), .bus(bs));

    vga_timing_pipe #(
        .H_FRONT(2), .H_SYNC(3), .H_BACK(2), .H_ACT(4),
        .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .V_ACT(3),
        .HS_POL(1), .VS_POL(1), .REQ_LEAD(2), .COLOR_W(10), .ADDR_W(22)
    ) u_inv (.iCLK(clk), .iRST_N(rst_n), .bus(bi));

    vga_timing_pipe u_big (.iCLK(clk), .iRST_N(rst_big_n), .bus(bb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Host for the small raster: returns colour for the request made two cycles earlier.
    initial begin : host_model
        logic        h_req  [2];
        logic [21:0] h_addr [2];
        h_req[0] = 1'b0; h_req[1] = 1'b0; h_addr[0] = 22'd0; h_addr[1] = 22'd0;
        bs.iRed = 10'd0; bs.iGreen = 10'h3FF; bs.iBlue = 10'd0;
        forever begin
            @(negedge clk);
            if (h_req[1] === 1'b1) begin
                bs.iRed  = h_addr[1][9:0];
                bs.iBlue = h_addr[1][9:0] + 10'd5;
            end else begin
                bs.iRed  = 10'd0;
                bs.iBlue = 10'd0;
            end
            h_req[1] = h_req[0]; h_addr[1] = h_addr[0];
            h_req[0] = bs.oRequest; h_addr[0] = bs.oAddress;
        end
    end

    task automatic release_small();
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks_total++;
        if ({bs.oRequest, bs.oCurrent_X, bs.oCurrent_Y, bs.oAddress, bs.oFrame_Start, bs.oLine_Start} !== 47'd0)
            $display("FAIL reset_req_bus: got %h expected 0", {bs.oRequest, bs.oCurrent_X, bs.oCurrent_Y, bs.oAddress, bs.oFrame_Start, bs.oLine_Start});
        else checks_passed++;
        checks_total++;
        if ({bs.oVGA_R, bs.oVGA_G, bs.oVGA_B, bs.oVGA_BLANK} !== 31'd0)
            $display("FAIL reset_rgb_blank: got %h expected 0", {bs.oVGA_R, bs.oVGA_G, bs.oVGA_B, bs.oVGA_BLANK});
        else checks_passed++;
        checks_total++;
        if ({bs.oVGA_HS, bs.oVGA_VS, bi.oVGA_HS, bi.oVGA_VS, bs.oVGA_SYNC} !== 5'b11001)
            $display("FAIL reset_sync: got %b expected 11001", {bs.oVGA_HS, bs.oVGA_VS, bi.oVGA_HS, bi.oVGA_VS, bs.oVGA_SYNC});
        else checks_passed++;
    endtask

    task automatic test_small_frame();
        int first_req = -1;
        int first_blank = -1;
        int n_fs = 0, n_ls = 0, n_hs = 0, n_vs = 0, n_bl = 0;
        int n_ihs = 0, n_ivs = 0, n_same = 0, bad_rgb = 0;
        logic [9:0] pix[$];
        release_small();
        for (int c = 0; c < 140; c++) begin
            if (c != 0) @(negedge clk);
            if (bs.oRequest === 1'b1 && first_req < 0) first_req = c;
            if (bs.oVGA_BLANK === 1'b1) begin
                if (first_blank < 0) first_blank = c;
                pix.push_back(bs.oVGA_R);
                if (bs.oVGA_G !== 10'h3FF || bs.oVGA_B !== bs.oVGA_R + 10'd5) bad_rgb++;
            end else if ({bs.oVGA_R, bs.oVGA_G, bs.oVGA_B} !== 30'd0) begin
                bad_rgb++;
            end
            if (bs.oFrame_Start === 1'b1) n_fs++;
            if (c >= 66 && c < 132) begin
                if (bs.oLine_Start === 1'b1) n_ls++;
                if (bs.oVGA_HS === 1'b0) n_hs++;
                if (bs.oVGA_VS === 1'b0) n_vs++;
                if (bs.oVGA_BLANK === 1'b1) n_bl++;
                if (bi.oVGA_HS === 1'b1) n_ihs++;
                if (bi.oVGA_VS === 1'b1) n_ivs++;
                if (bi.oVGA_HS === bs.oVGA_HS || bi.oVGA_VS === bs.oVGA_VS) n_same++;
            end
            if (c == 0) begin
                checks_total++;
                if ({bs.oFrame_Start, bs.oLine_Start, bs.oRequest} !== 3'b110)
                    $display("FAIL small_first_pos: got %b expected 110", {bs.oFrame_Start, bs.oLine_Start, bs.oRequest});
                else checks_passed++;
            end
            if (c == 40) begin
                checks_total++;
                if ({bs.oRequest, bs.oCurrent_X, bs.oCurrent_Y, bs.oAddress} !== {1'b1, 11'd0, 11'd0, 22'd0})
                    $display("FAIL small_first_req_vals: got %b/%0d/%0d/%0d expected 1/0/0/0", bs.oRequest, bs.oCurrent_X, bs.oCurrent_Y, bs.oAddress);
                else checks_passed++;
            end
            if (c == 65) begin
                checks_total++;
                if ({bs.oRequest, bs.oCurrent_X, bs.oCurrent_Y, bs.oAddress} !== {1'b1, 11'd3, 11'd2, 22'd11})
                    $display("FAIL small_last_pixel: got %b/%0d/%0d/%0d expected 1/3/2/11", bs.oRequest, bs.oCurrent_X, bs.oCurrent_Y, bs.oAddress);
                else checks_passed++;
            end
            if (c == 66) begin
                checks_total++;
                if ({bs.oFrame_Start, bs.oRequest, bs.oAddress} !== {1'b1, 1'b0, 22'd0})
                    $display("FAIL small_wrap: got fs=%b req=%b addr=%0d expected 1/0/0", bs.oFrame_Start, bs.oRequest, bs.oAddress);
                else checks_passed++;
            end
            if (c == 106) begin
                checks_total++;
                if ({bs.oRequest, bs.oAddress} !== {1'b1, 22'd0})
                    $display("FAIL small_frame2_addr: got req=%b addr=%0d expected 1/0", bs.oRequest, bs.oAddress);
                else checks_passed++;
            end
            if (c == 4 || c == 5 || c == 7 || c == 8) begin
                checks_total++;
                if (bs.oVGA_HS !== ((c == 5 || c == 7) ? 1'b0 : 1'b1))
                    $display("FAIL small_hs_edge: cycle %0d got %b", c, bs.oVGA_HS);
                else checks_passed++;
            end
            if (c == 13 || c == 14 || c == 24 || c == 25) begin
                checks_total++;
                if (bs.oVGA_VS !== ((c == 14 || c == 24) ? 1'b0 : 1'b1))
                    $display("FAIL small_vs_edge: cycle %0d got %b", c, bs.oVGA_VS);
                else checks_passed++;
            end
        end
        checks_total++;
        if (first_req != 40) $display("FAIL small_first_req_cycle: got %0d expected 40", first_req);
        else checks_passed++;
        checks_total++;
        if (first_blank != 43) $display("FAIL small_first_blank: got %0d expected 43", first_blank);
        else checks_passed++;
        checks_total++;
        if (pix.size() != 24) $display("FAIL small_pixel_count: got %0d expected 24", pix.size());
        else checks_passed++;
        for (int i = 0; i < pix.size() && i < 24; i++) begin
            checks_total++;
            if (pix[i] !== 10'(i % 12)) $display("FAIL small_pixel_value: index %0d got %0d expected %0d", i, pix[i], i % 12);
            else checks_passed++;
        end
        checks_total++;
        if (bad_rgb != 0) $display("FAIL small_rgb_gating: got %0d bad cycles expected 0", bad_rgb);
        else checks_passed++;
        checks_total++;
        if ({n_fs, n_ls, n_hs, n_vs, n_bl} !== {32'd3, 32'd6, 32'd18, 32'd11, 32'd12})
            $display("FAIL small_counts: got fs=%0d ls=%0d hs=%0d vs=%0d bl=%0d expected 3/6/18/11/12", n_fs, n_ls, n_hs, n_vs, n_bl);
        else checks_passed++;
        checks_total++;
        if ({n_ihs, n_ivs, n_same} !== {32'd18, 32'd11, 32'd0})
            $display("FAIL small_inverted_sync: got hs=%0d vs=%0d same=%0d expected 18/11/0", n_ihs, n_ivs, n_same);
        else checks_passed++;
    endtask

    task automatic test_mid_reset();
        int first_nz = -1;
        // Last sample of the previous task was cycle 139; cycle 184 is mid-active on line 1 of frame 2.
        repeat (45) @(negedge clk);
        checks_total++;
        if ({bs.oRequest, bs.oCurrent_X, bs.oCurrent_Y, bs.oAddress} !== {1'b1, 11'd1, 11'd1, 22'd5})
            $display("FAIL midrst_pre_pos: got %b/%0d/%0d/%0d expected 1/1/1/5", bs.oRequest, bs.oCurrent_X, bs.oCurrent_Y, bs.oAddress);
        else checks_passed++;
        rst_n = 1'b0;
        @(negedge clk);
        checks_total++;
        if ({bs.oRequest, bs.oCurrent_X, bs.oCurrent_Y, bs.oAddress, bs.oFrame_Start, bs.oLine_Start} !== 47'd0)
            $display("FAIL midrst_req_bus: got %h expected 0", {bs.oRequest, bs.oCurrent_X, bs.oCurrent_Y, bs.oAddress, bs.oFrame_Start, bs.oLine_Start});
        else checks_passed++;
        checks_total++;
        if ({bs.oVGA_R, bs.oVGA_G, bs.oVGA_B, bs.oVGA_BLANK, bs.oVGA_HS, bs.oVGA_VS} !== {31'd0, 2'b11})
            $display("FAIL midrst_display: got %h expected %h", {bs.oVGA_R, bs.oVGA_G, bs.oVGA_B, bs.oVGA_BLANK, bs.oVGA_HS, bs.oVGA_VS}, {31'd0, 2'b11});
        else checks_passed++;
        @(negedge clk);
        release_small();
        for (int c = 0; c < 50; c++) begin
            if (c != 0) @(negedge clk);
            if (first_nz < 0 && {bs.oVGA_R, bs.oVGA_G, bs.oVGA_B} !== 30'd0) first_nz = c;
            if (c == 0) begin
                checks_total++;
                if ({bs.oFrame_Start, bs.oLine_Start} !== 2'b11)
                    $display("FAIL midrst_restart: got %b expected 11", {bs.oFrame_Start, bs.oLine_Start});
                else checks_passed++;
            end
        end
        checks_total++;
        if (first_nz != 43) $display("FAIL midrst_first_rgb: got cycle %0d expected 43", first_nz);
        else checks_passed++;
    endtask

    task automatic test_default();
        int first_req = -1;
        int n_fs = 0, n_ls = 0, n_hs0 = 0, n_hs1 = 0, n_vs = 0, n_bl = 0, bad_rgb = 0;
        @(negedge clk); rst_big_n = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 36810; c++) begin
            if (c != 0) @(negedge clk);
            if (bb.oRequest === 1'b1 && first_req < 0) first_req = c;
            if (bb.oFrame_Start === 1'b1) n_fs++;
            if (bb.oLine_Start === 1'b1) n_ls++;
            if (bb.oVGA_HS === 1'b0 && c < 800) n_hs0++;
            if (bb.oVGA_HS === 1'b0 && c >= 800 && c < 1600) n_hs1++;
            if (bb.oVGA_VS === 1'b0) n_vs++;
            if (bb.oVGA_BLANK === 1'b1) begin
                n_bl++;
                if (bb.oVGA_R !== 10'h155) bad_rgb++;
            end else if (bb.oVGA_R !== 10'd0) begin
                bad_rgb++;
            end
            if (c == 36160) begin
                checks_total++;
                if ({bb.oRequest, bb.oCurrent_X, bb.oCurrent_Y, bb.oAddress} !== {1'b1, 11'd0, 11'd0, 22'd0})
                    $display("FAIL dflt_first_req_vals: got %b/%0d/%0d/%0d expected 1/0/0/0", bb.oRequest, bb.oCurrent_X, bb.oCurrent_Y, bb.oAddress);
                else checks_passed++;
            end
            if (c == 36799) begin
                checks_total++;
                if ({bb.oRequest, bb.oCurrent_X, bb.oCurrent_Y, bb.oAddress} !== {1'b1, 11'd639, 11'd0, 22'd639})
                    $display("FAIL dflt_line_end: got %b/%0d/%0d/%0d expected 1/639/0/639", bb.oRequest, bb.oCurrent_X, bb.oCurrent_Y, bb.oAddress);
                else checks_passed++;
            end
        end
        checks_total++;
        if (first_req != 36160) $display("FAIL dflt_first_req_cycle: got %0d expected 36160", first_req);
        else checks_passed++;
        checks_total++;
        if ({n_hs0, n_hs1} !== {32'd96, 32'd96}) $display("FAIL dflt_hs_width: got %0d/%0d expected 96/96", n_hs0, n_hs1);
        else checks_passed++;
        checks_total++;
        if (n_vs != 1600) $display("FAIL dflt_vs_width: got %0d expected 1600", n_vs);
        else checks_passed++;
        checks_total++;
        if (n_bl != 640) $display("FAIL dflt_blank_line: got %0d expected 640", n_bl);
        else checks_passed++;
        checks_total++;
        if ({n_fs, n_ls} !== {32'd1, 32'd47}) $display("FAIL dflt_starts: got fs=%0d ls=%0d expected 1/47", n_fs, n_ls);
        else checks_passed++;
        checks_total++;
        if (bad_rgb != 0) $display("FAIL dflt_rgb_gating: got %0d bad cycles expected 0", bad_rgb);
        else checks_passed++;
    endtask

    initial begin
        checks_total = 0;
        checks_passed = 0;
        rst_n = 1'b0;
        rst_big_n = 1'b0;
        bi.iRed = 10'h2AA; bi.iGreen = 10'h2AA; bi.iBlue = 10'h2AA;
        bb.iRed = 10'h155; bb.iGreen = 10'd0;   bb.iBlue = 10'd0;
        test_reset();
        test_small_frame();
        test_mid_reset();
        test_default();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule
